async_fifo_rd_ctrl: RTL

Read-domain controller for the async FIFO. It brings the write pointer into `rclk` through a synchronizer chain whose depth is set by a parameter. It keeps the read pointer in both binary and Gray form and produces a registered empty flag. Beyond a bare pointer synchronizer, it also provides a fill count, an almost-empty flag and a sticky underflow flag.

---
 rtl/async_fifo_rd_ctrl.sv | 75 +++++++
 1 files changed

// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain side of the async FIFO: synchronizes the Gray write pointer into
// rclk, advances the read pointer and derives empty, fill count and error flags.
module async_fifo_rd_ctrl #(
  parameter int ASIZE       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_LEVEL    = 1
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [ASIZE:0]   wptr,
  input  logic             rinc,
  input  logic             rclr_err,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   rcount,
  output logic             runderflow
);

  localparam logic [ASIZE:0] AE_LVL = (ASIZE+1)'(AE_LEVEL);

  logic [ASIZE:0] wq [SYNC_STAGES];
  logic [ASIZE:0] wq_sync;
  logic [ASIZE:0] wbin_s;
  logic [ASIZE:0] rbin;
  logic [ASIZE:0] rbin_next;
  logic [ASIZE:0] rgray_next;
  logic [ASIZE:0] fill_next;
  logic           rd_en;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) wq[i] <= '0;
    end else begin
      wq[0] <= wptr;
      for (int i = 1; i < SYNC_STAGES; i++) wq[i] <= wq[i-1];
    end
  end

  assign wq_sync = wq[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= ASIZE; i++) wbin_s[i] = ^(wq_sync >> i);
  end

  assign rd_en      = rinc & ~rempty;
  assign rbin_next  = rbin + {{ASIZE{1'b0}}, rd_en};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign fill_next  = wbin_s - rbin_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      rcount        <= '0;
      ralmost_empty <= 1'b1;
      runderflow    <= 1'b0;
    end else begin
      rbin          <= rbin_next;
      rptr          <= rgray_next;
      rempty        <= (rgray_next == wq_sync);
      rcount        <= fill_next;
      ralmost_empty <= (fill_next <= AE_LVL);
      // A new underflow outranks a simultaneous clear.
      runderflow    <= (rinc & rempty) | (runderflow & ~rclr_err);
    end
  end

  assign raddr = rbin[ASIZE-1:0];

endmodule
